// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU with one transaction in flight.
// LSU has priority, fetch gets a starvation override, and a timer ends hung responses.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req_ip,
    input  logic [ADDR_WIDTH-1:0] if_addr_ip,
    output logic                  if_gnt_op,
    output logic                  if_rvalid_op,
    output logic [DATA_WIDTH-1:0] if_rdata_op,
    output logic                  if_err_op,
    input  logic                  lsu_req_ip,
    input  logic                  lsu_we_ip,
    input  logic [3:0]            lsu_be_ip,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_ip,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_ip,
    output logic                  lsu_gnt_op,
    output logic                  lsu_rvalid_op,
    output logic [DATA_WIDTH-1:0] lsu_rdata_op,
    output logic                  lsu_err_op,
    output logic                  mem_req_op,
    output logic [ADDR_WIDTH-1:0] mem_addr_op,
    output logic                  mem_we_op,
    output logic [3:0]            mem_be_op,
    output logic [DATA_WIDTH-1:0] mem_wdata_op,
    input  logic                  mem_gnt_ip,
    input  logic                  mem_rvalid_ip,
    input  logic [DATA_WIDTH-1:0] mem_rdata_ip,
    output logic                  busy_op
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int TM_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LSU} owner_t;

    state_t                state, state_next;
    owner_t                owner, owner_next;
    logic [SC_W-1:0]       starve_cnt, starve_next;
    logic [TM_W-1:0]       timer, timer_next;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic                  hold_we;
    logic [3:0]            hold_be;
    logic [DATA_WIDTH-1:0] hold_wdata;

    logic fetch_win, lsu_win, timed_out, rsp_ok, rsp_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            timer      <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            starve_cnt <= starve_next;
            timer      <= timer_next;
        end
    end

    // Fetch requests carry no store data, so they are latched as full-word reads.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_addr  <= '0;
            hold_we    <= 1'b0;
            hold_be    <= 4'h0;
            hold_wdata <= '0;
        end else if (fetch_win) begin
            hold_addr  <= if_addr_ip;
            hold_we    <= 1'b0;
            hold_be    <= 4'hF;
            hold_wdata <= '0;
        end else if (lsu_win) begin
            hold_addr  <= lsu_addr_ip;
            hold_we    <= lsu_we_ip;
            hold_be    <= lsu_be_ip;
            hold_wdata <= lsu_wdata_ip;
        end
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        starve_next = starve_cnt;
        timer_next  = timer;
        fetch_win   = 1'b0;
        lsu_win     = 1'b0;

        if (state == IDLE) begin
            fetch_win = if_req_ip && (!lsu_req_ip || (starve_cnt >= SC_W'(STARVE_LIMIT)));
            lsu_win   = lsu_req_ip && !fetch_win;
        end
        timed_out = (state != IDLE) && (timer == TM_W'(TIMEOUT - 1));
        rsp_ok    = (state == WAIT) && mem_rvalid_ip;
        rsp_done  = rsp_ok || timed_out;

        case (state)
            IDLE: begin
                if (fetch_win) begin
                    state_next  = REQ;
                    owner_next  = OWN_IF;
                    starve_next = '0;
                    timer_next  = '0;
                end else if (lsu_win) begin
                    state_next = REQ;
                    owner_next = OWN_LSU;
                    timer_next = '0;
                    if (if_req_ip && (starve_cnt < SC_W'(STARVE_LIMIT)))
                        starve_next = starve_cnt + 1'b1;
                end
            end
            REQ: begin
                timer_next = timer + 1'b1;
                if (timed_out) begin
                    state_next = IDLE;
                    owner_next = OWN_NONE;
                    timer_next = '0;
                end else if (mem_gnt_ip) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                timer_next = timer + 1'b1;
                if (rsp_done) begin
                    state_next = IDLE;
                    owner_next = OWN_NONE;
                    timer_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                owner_next = OWN_NONE;
            end
        endcase

        if_gnt_op  = fetch_win;
        lsu_gnt_op = lsu_win;

        // A timeout in REQ withdraws the request so memory cannot grant a dead transaction.
        mem_req_op   = (state == REQ) && !timed_out;
        mem_addr_op  = mem_req_op ? hold_addr  : '0;
        mem_we_op    = mem_req_op ? hold_we    : 1'b0;
        mem_be_op    = mem_req_op ? hold_be    : 4'h0;
        mem_wdata_op = mem_req_op ? hold_wdata : '0;

        if_rvalid_op  = rsp_done && (owner == OWN_IF);
        lsu_rvalid_op = rsp_done && (owner == OWN_LSU);
        if_rdata_op   = (rsp_ok && (owner == OWN_IF))  ? mem_rdata_ip : '0;
        lsu_rdata_op  = (rsp_ok && (owner == OWN_LSU)) ? mem_rdata_ip : '0;
        if_err_op     = if_rvalid_op && !rsp_ok;
        lsu_err_op    = lsu_rvalid_op && !rsp_ok;

        busy_op = (state != IDLE);
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table of whole transactions plus hand-written
// sequences for the late-response and mid-transaction reset cases.
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        if_req;
        logic        lsu_req;
        logic        lsu_we;
        logic [3:0]  lsu_be;
        logic [31:0] if_addr;
        logic [31:0] lsu_addr;
        logic [31:0] lsu_wdata;
        int          gnt_delay;
        int          rv_cycle;
        logic [31:0] rdata;
        logic        exp_lsu;
    } vec_t;

    typedef struct {
        logic        is_lsu;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clock, reset;
    logic        if_req_ip, if_gnt_op, if_rvalid_op, if_err_op;
    logic [31:0] if_addr_ip, if_rdata_op;
    logic        lsu_req_ip, lsu_we_ip, lsu_gnt_op, lsu_rvalid_op, lsu_err_op;
    logic [3:0]  lsu_be_ip;
    logic [31:0] lsu_addr_ip, lsu_wdata_ip, lsu_rdata_op;
    logic        mem_req_op, mem_we_op, mem_gnt_ip, mem_rvalid_ip, busy_op;
    logic [3:0]  mem_be_op;
    logic [31:0] mem_addr_op, mem_wdata_op, mem_rdata_ip;

    int   compared = 0;
    int   failed   = 0;
    rsp_t sb_q[$];
    vec_t vecs[13];

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .if_req_ip(if_req_ip), .if_addr_ip(if_addr_ip), .if_gnt_op(if_gnt_op),
        .if_rvalid_op(if_rvalid_op), .if_rdata_op(if_rdata_op), .if_err_op(if_err_op),
        .lsu_req_ip(lsu_req_ip), .lsu_we_ip(lsu_we_ip), .lsu_be_ip(lsu_be_ip),
        .lsu_addr_ip(lsu_addr_ip), .lsu_wdata_ip(lsu_wdata_ip), .lsu_gnt_op(lsu_gnt_op),
        .lsu_rvalid_op(lsu_rvalid_op), .lsu_rdata_op(lsu_rdata_op), .lsu_err_op(lsu_err_op),
        .mem_req_op(mem_req_op), .mem_addr_op(mem_addr_op), .mem_we_op(mem_we_op),
        .mem_be_op(mem_be_op), .mem_wdata_op(mem_wdata_op), .mem_gnt_ip(mem_gnt_ip),
        .mem_rvalid_ip(mem_rvalid_ip), .mem_rdata_ip(mem_rdata_ip), .busy_op(busy_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every response the DUT raises must match the oldest expectation in the scoreboard.
    always @(negedge clock) begin
        rsp_t e;
        if (if_rvalid_op === 1'b1 || lsu_rvalid_op === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_output("sb_unexpected_rvalid", {30'd0, lsu_rvalid_op, if_rvalid_op}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_output("rsp_if_rvalid", if_rvalid_op, !e.is_lsu);
                check_output("rsp_lsu_rvalid", lsu_rvalid_op, e.is_lsu);
                check_output("rsp_rdata", e.is_lsu ? lsu_rdata_op : if_rdata_op, e.data);
                check_output("rsp_err", e.is_lsu ? lsu_err_op : if_err_op, e.err);
                check_output("rsp_other_err", e.is_lsu ? if_err_op : lsu_err_op, 32'd0);
            end
        end
        if (if_rvalid_op !== 1'b1) check_output("if_rdata_quiet", if_rdata_op, 32'd0);
        if (lsu_rvalid_op !== 1'b1) check_output("lsu_rdata_quiet", lsu_rdata_op, 32'd0);
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Runs one whole transaction starting from an IDLE cycle; the memory side is scripted by the vector.
    task automatic apply_stimulus(input vec_t v);
        int          n;
        bit          done;
        rsp_t        rsp;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;

        e_addr = v.exp_lsu ? v.lsu_addr : v.if_addr;
        e_we   = v.exp_lsu ? v.lsu_we : 1'b0;
        e_be   = v.exp_lsu ? v.lsu_be : 4'hF;

        if_req_ip     = v.if_req;
        if_addr_ip    = v.if_addr;
        lsu_req_ip    = v.lsu_req;
        lsu_we_ip     = v.lsu_we;
        lsu_be_ip     = v.lsu_be;
        lsu_addr_ip   = v.lsu_addr;
        lsu_wdata_ip  = v.lsu_wdata;
        mem_gnt_ip    = 1'b0;
        mem_rvalid_ip = 1'b0;
        @(negedge clock);
        check_output("if_gnt", if_gnt_op, !v.exp_lsu);
        check_output("lsu_gnt", lsu_gnt_op, v.exp_lsu);
        check_output("busy_idle", busy_op, 32'd0);
        next_cycle();
        n = 1;

        for (int k = 0; k <= v.gnt_delay; k++) begin
            mem_gnt_ip    = (k == v.gnt_delay);
            mem_rvalid_ip = (k != v.gnt_delay);
            mem_rdata_ip  = $urandom;
            @(negedge clock);
            check_output("req_mem_req", mem_req_op, 32'd1);
            check_output("req_mem_addr", mem_addr_op, e_addr);
            check_output("req_mem_we", mem_we_op, e_we);
            check_output("req_mem_be", mem_be_op, e_be);
            if (v.exp_lsu) check_output("req_mem_wdata", mem_wdata_op, v.lsu_wdata);
            check_output("busy_req", busy_op, 32'd1);
            next_cycle();
            n++;
        end
        mem_gnt_ip = 1'b0;

        done = 0;
        while (!done) begin
            mem_rvalid_ip = (n == v.rv_cycle);
            mem_rdata_ip  = (n == v.rv_cycle) ? v.rdata : $urandom;
            if (n == v.rv_cycle || n == TIMEOUT) begin
                rsp.is_lsu = v.exp_lsu;
                rsp.err    = (n != v.rv_cycle);
                rsp.data   = rsp.err ? 32'd0 : v.rdata;
                sb_q.push_back(rsp);
                done = 1;
            end
            @(negedge clock);
            check_output("wait_mem_req", mem_req_op, 32'd0);
            check_output("busy_wait", busy_op, 32'd1);
            next_cycle();
            n++;
        end
        mem_rvalid_ip = 1'b0;
        check_output("sb_drained", sb_q.size(), 32'd0);
        check_output("busy_after", busy_op, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0,   32'h0,        0, 2,  32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'h3, 32'h104, 32'h200, 32'h55AA,     0, 2,  32'h0,        1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h104, 32'h0,   32'h0,        0, 2,  32'h11112222, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h108, 32'h300, 32'h0,        0, 2,  32'hA0A00001, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h108, 32'h304, 32'h0,        0, 2,  32'hA0A00002, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h108, 32'h308, 32'h0,        0, 2,  32'hA0A00003, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h108, 32'h30C, 32'h0,        0, 2,  32'hA0A00004, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 4'hF, 32'h108, 32'h310, 32'h0,        1, 3,  32'hC0DE0007, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'hC, 32'h10C, 32'h310, 32'h12345678, 0, 2,  32'h0,        1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'h1, 32'h0,   32'h400, 32'h0,        3, 6,  32'hCAFE0009, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0,   32'h500, 32'h0,        0, 0,  32'h0,        1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h600, 32'h0,   32'h0,        0, 16, 32'h600DD00D, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h700, 32'h0,   32'h0,        0, 2,  32'h77778888, 1'b0};

        reset = 1'b1;
        if_req_ip = 1'b0; if_addr_ip = '0;
        lsu_req_ip = 1'b0; lsu_we_ip = 1'b0; lsu_be_ip = 4'h0; lsu_addr_ip = '0; lsu_wdata_ip = '0;
        mem_gnt_ip = 1'b0; mem_rvalid_ip = 1'b0; mem_rdata_ip = '0;
        #2;
        check_output("rst_busy", busy_op, 32'd0);
        check_output("rst_mem_req", mem_req_op, 32'd0);
        check_output("rst_mem_addr", mem_addr_op, 32'd0);
        check_output("rst_gnts", {if_gnt_op, lsu_gnt_op}, 32'd0);
        check_output("rst_rvalids", {if_rvalid_op, lsu_rvalid_op}, 32'd0);
        check_output("rst_rdata", if_rdata_op | lsu_rdata_op, 32'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i]);
            if (i == 10) begin
                if_req_ip     = 1'b0;
                lsu_req_ip    = 1'b0;
                mem_rvalid_ip = 1'b1;
                mem_rdata_ip  = 32'hBAD0BAD0;
                @(negedge clock);
                check_output("late_if_rvalid", if_rvalid_op, 32'd0);
                check_output("late_lsu_rvalid", lsu_rvalid_op, 32'd0);
                check_output("late_busy", busy_op, 32'd0);
                next_cycle();
                mem_rvalid_ip = 1'b0;
            end
        end

        // Reset lands mid-cycle while WAIT has a response on the bus; it must vanish at once.
        if_req_ip  = 1'b1;
        if_addr_ip = 32'h440;
        lsu_req_ip = 1'b0;
        next_cycle();
        mem_gnt_ip = 1'b1;
        next_cycle();
        mem_gnt_ip = 1'b0;
        if_req_ip  = 1'b0;
        check_output("pre_rst_busy", busy_op, 32'd1);
        #2;
        reset         = 1'b1;
        mem_rvalid_ip = 1'b1;
        mem_rdata_ip  = 32'hFFFF0000;
        #1;
        check_output("midrst_busy", busy_op, 32'd0);
        check_output("midrst_mem_req", mem_req_op, 32'd0);
        check_output("midrst_rvalids", {if_rvalid_op, lsu_rvalid_op}, 32'd0);
        next_cycle();
        reset         = 1'b0;
        mem_rvalid_ip = 1'b0;
        next_cycle();
        apply_stimulus(vecs[12]);

        if_req_ip  = 1'b0;
        lsu_req_ip = 1'b0;
        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
